// File: rtl/timer_pkg.sv
// Shared helpers for the timer block: parameter legality check used at
// elaboration time.
package timer_pkg;

    // True when a terminal count of max_val is representable in dw bits and
    // dw itself is a usable width.
    function automatic bit max_fits(int dw, longint unsigned max_val);
        if (dw < 1) begin
            return 1'b0;
        end
        if (dw >= 63) begin
            return 1'b1;
        end
        return max_val <= ((64'd1 << dw) - 64'd1);
    endfunction

endpackage

// File: rtl/timer.sv
// Periodic timer: counts enabled cycles 0..MAX, wraps, and emits a one-cycle
// registered irq pulse on the cycle after the wrap. Dropping enable pauses
// the count without clearing it.
module timer
    import timer_pkg::*;
#(
    parameter int          DW  = 8,
    parameter int unsigned MAX = 14
) (
    input  logic          clk,
    input  logic          rst_n,     // active-high synchronous reset
    input  logic          enable,
    output logic          irq,
    output logic [DW-1:0] count
);

    localparam logic [DW-1:0] TERM = DW'(MAX);

    if (!max_fits(DW, 64'(MAX))) begin : g_param_check
        $error("timer: MAX does not fit in DW bits, or DW < 1");
    end

    logic at_term;

    assign at_term = (count == TERM);

    // Counter register and irq register; irq is only set by an enabled edge at terminal count.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            count <= '0;
            irq   <= 1'b0;
        end else begin
            irq <= enable && at_term;
            if (enable) begin
                count <= at_term ? '0 : count + DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_timer.sv
// Directed and randomized checks of the timer at MAX=14, MAX=0 and MAX=255.
module tb_timer;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       irq_a, irq_z, irq_f;
    logic [7:0] cnt_a, cnt_z, cnt_f;

    int checks = 0;
    int errors = 0;

    // Reference model state, index 0: MAX=14, 1: MAX=0, 2: MAX=255
    int mx[3] = '{14, 0, 255};
    int mc[3];
    int mi[3];

    timer #(.DW(8), .MAX(14))  u_dut_a (.clk(clk), .rst_n(rst_n), .enable(enable), .irq(irq_a), .count(cnt_a));
    timer #(.DW(8), .MAX(0))   u_dut_z (.clk(clk), .rst_n(rst_n), .enable(enable), .irq(irq_z), .count(cnt_z));
    timer #(.DW(8), .MAX(255)) u_dut_f (.clk(clk), .rst_n(rst_n), .enable(enable), .irq(irq_f), .count(cnt_f));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: inputs seen at the edge are those set before the call.
    task automatic tick();
        logic e, r;
        e = enable;
        r = rst_n;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                mc[k] = 0;
                mi[k] = 0;
            end else begin
                mi[k] = (e && mc[k] == mx[k]) ? 1 : 0;
                if (e) mc[k] = (mc[k] == mx[k]) ? 0 : mc[k] + 1;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b1;
        enable = 1'b1;
        tick();
        chk("reset_cnt_a", int'(cnt_a), 0);
        chk("reset_irq_a", int'(irq_a), 0);
        chk("reset_cnt_z", int'(cnt_z), 0);
        chk("reset_irq_z", int'(irq_z), 0);
        chk("reset_cnt_f", int'(cnt_f), 0);
        chk("reset_irq_f", int'(irq_f), 0);

        // Free run: irq after the 15th and 30th enabled edges
        rst_n = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            chk($sformatf("free_cnt_%0d", i), int'(cnt_a), i % 15);
            chk($sformatf("free_irq_%0d", i), int'(irq_a), (i % 15 == 0) ? 1 : 0);
            chk($sformatf("max0_cnt_%0d", i), int'(cnt_z), 0);
            chk($sformatf("max0_irq_%0d", i), int'(irq_z), 1);
            chk($sformatf("max255_cnt_%0d", i), int'(cnt_f), i);
        end

        // Pause: 17 enabled, 4 paused at count 2, then 13 more to irq
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            tick();
            if (i == 15) chk("pause_irq15", int'(irq_a), 1);
            if (i == 16) chk("pause_irq16", int'(irq_a), 0);
        end
        chk("pause_cnt17", int'(cnt_a), 2);
        enable = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("pause_hold_cnt_%0d", i), int'(cnt_a), 2);
            chk($sformatf("pause_hold_irq_%0d", i), int'(irq_a), 0);
            chk($sformatf("pause_max0_irq_%0d", i), int'(irq_z), 0);
        end
        enable = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            tick();
            chk($sformatf("resume_cnt_%0d", i), int'(cnt_a), (2 + i) % 15);
            chk($sformatf("resume_irq_%0d", i), int'(irq_a), (i == 13) ? 1 : 0);
        end

        // Reset at count 9, then a full 15-edge period
        do_reset();
        for (int i = 1; i <= 9; i++) tick();
        chk("midrst_pre_cnt", int'(cnt_a), 9);
        rst_n = 1'b1;
        tick();
        chk("midrst_cnt", int'(cnt_a), 0);
        chk("midrst_irq", int'(irq_a), 0);
        rst_n = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk($sformatf("midrst_run_irq_%0d", i), int'(irq_a), (i == 15) ? 1 : 0);
        end
        chk("midrst_run_cnt", int'(cnt_a), 0);

        // Enable drop exactly at terminal count
        do_reset();
        for (int i = 1; i <= 14; i++) tick();
        chk("drop_pre_cnt", int'(cnt_a), 14);
        enable = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("drop_cnt_%0d", i), int'(cnt_a), 14);
            chk($sformatf("drop_irq_%0d", i), int'(irq_a), 0);
        end
        enable = 1'b1;
        tick();
        chk("drop_resume_irq", int'(irq_a), 1);
        chk("drop_resume_cnt", int'(cnt_a), 0);
        tick();
        chk("drop_after_irq", int'(irq_a), 0);
        chk("drop_after_cnt", int'(cnt_a), 1);

        // Full-width wrap at MAX=255
        do_reset();
        for (int i = 1; i <= 255; i++) tick();
        chk("wrap255_cnt", int'(cnt_f), 255);
        chk("wrap255_irq", int'(irq_f), 0);
        tick();
        chk("wrap256_cnt", int'(cnt_f), 0);
        chk("wrap256_irq", int'(irq_f), 1);
        tick();
        chk("wrap257_irq", int'(irq_f), 0);
        chk("wrap257_cnt", int'(cnt_f), 1);

        // Random enable against the reference model
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            enable = ($urandom_range(0, 3) != 0);
            rst_n  = ($urandom_range(0, 99) == 0);
            tick();
            chk("rand_cnt_a", int'(cnt_a), mc[0]);
            chk("rand_irq_a", int'(irq_a), mi[0]);
            chk("rand_cnt_z", int'(cnt_z), mc[1]);
            chk("rand_irq_z", int'(irq_z), mi[1]);
            chk("rand_cnt_f", int'(cnt_f), mc[2]);
            chk("rand_irq_f", int'(irq_f), mi[2]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
